// File: rtl/pmc_shifter_if.sv
// Bundle of control, status and serial matrix signals for the pixel-matrix shifter.
// The slave side is the shifter; the master side is the controller or the matrix model.
interface pmc_shifter_if #(
  parameter int LANES = 16,
  parameter int WIDTH = 32
);
  logic                   start;
  logic                   abort;
  logic [5:0]             bit_cnt;
  logic [7:0]             half_period;
  logic [LANES*WIDTH-1:0] dout_in;
  logic [LANES*WIDTH-1:0] din_out;
  logic                   busy;
  logic                   done;
  logic                   clk_sh;
  logic [LANES-1:0]       sh_dout;
  logic [LANES-1:0]       sh_din;

  modport master (
    output start, abort, bit_cnt, half_period, dout_in, sh_din,
    input  din_out, busy, done, clk_sh, sh_dout
  );

  modport slave (
    input  start, abort, bit_cnt, half_period, dout_in, sh_din,
    output din_out, busy, done, clk_sh, sh_dout
  );
endinterface

// File: rtl/pmc_shifter.sv
// Parallel pixel-matrix shifter: clocks bit_cnt bits through LANES serial lanes,
// MSB first, capturing the returning bits into the same lane registers.
//
// state | meaning
// IDLE  | waiting for start; parameters and lane data latched on start
// LOW   | clk_sh low phase, half_period cycles
// HIGH  | clk_sh high phase, half_period cycles; lanes shift on its last cycle
// DONE  | lane registers copied to din_out, done pulse follows
module pmc_shifter #(
  parameter int LANES = 16,
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst,
  pmc_shifter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t                         state_q, state_d;
  logic [LANES-1:0][WIDTH-1:0]    lane_q;
  logic [LANES*WIDTH-1:0]         din_q;
  logic [5:0]                     rem_q;
  logic [7:0]                     hp_q;
  logic [7:0]                     ph_q;
  logic                           clk_sh_q;
  logic                           done_q;
  logic                           load;
  logic                           shift;
  logic                           finish;
  logic [5:0]                     cnt_sat;
  logic [7:0]                     hp_adj;

  assign cnt_sat = (bus.bit_cnt > 6'd32) ? 6'd32 : bus.bit_cnt;
  assign hp_adj  = (bus.half_period == 8'd0) ? 8'd1 : bus.half_period;

  // Next-state and phase-event decode; abort overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = (cnt_sat == 6'd0) ? DONE : LOW;
        end
      end
      LOW: begin
        if (ph_q == 8'd0) state_d = HIGH;
      end
      HIGH: begin
        if (ph_q == 8'd0) begin
          shift   = 1'b1;
          state_d = (rem_q == 6'd1) ? DONE : LOW;
        end
      end
      DONE: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      shift   = 1'b0;
      finish  = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Latched parameters, phase down-counter and remaining-bits counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= 6'd0;
      hp_q  <= 8'd0;
      ph_q  <= 8'd0;
    end else if (load) begin
      rem_q <= cnt_sat;
      hp_q  <= hp_adj;
      ph_q  <= hp_adj - 8'd1;
    end else if (state_q == LOW || state_q == HIGH) begin
      ph_q <= (ph_q == 8'd0) ? hp_q - 8'd1 : ph_q - 8'd1;
      if (shift) rem_q <= rem_q - 6'd1;
    end
  end

  // Lane registers: parallel load on start, shift left with sh_din entering bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= '0;
    end else if (load) begin
      lane_q <= bus.dout_in;
    end else if (shift) begin
      for (int k = 0; k < LANES; k++)
        lane_q[k] <= {lane_q[k][WIDTH-2:0], bus.sh_din[k]};
    end
  end

  // Registered outputs: clk_sh follows the upcoming state so it is glitch-free,
  // done and din_out update together when DONE completes without abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sh_q <= 1'b0;
      done_q   <= 1'b0;
      din_q    <= '0;
    end else begin
      clk_sh_q <= (state_d == HIGH);
      done_q   <= finish;
      if (finish) din_q <= lane_q;
    end
  end

  // MSB of each lane is presented to the matrix.
  always_comb begin
    bus.sh_dout = '0;
    for (int k = 0; k < LANES; k++)
      bus.sh_dout[k] = lane_q[k][WIDTH-1];
  end

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.clk_sh  = clk_sh_q;
  assign bus.din_out = din_q;

endmodule

// File: tb/tb_pmc_shifter.sv
// Scoreboard bench for pmc_shifter: stimulus pushes expected results, a monitor
// pops and checks them whenever done is seen.
module tb_pmc_shifter;
  localparam int LANES = 16;
  localparam int WIDTH = 32;
  localparam int LW    = LANES * WIDTH;

  typedef struct {
    logic [LW-1:0] din;
    int            lat;
    int            pulses;
    int            start_cyc;
    int            pbase;
    int            hw;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loop_mode = 1'b1;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  int   pulses_total = 0;
  int   last_hw = 0;
  exp_t sb[$];

  pmc_shifter_if #(.LANES(LANES), .WIDTH(WIDTH)) bus ();

  pmc_shifter #(.LANES(LANES), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.sh_din = loop_mode ? bus.sh_dout : {LANES{1'b1}};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference behaviour of one lane sequence: n left shifts, fill from MSB (loopback) or 1.
  function automatic logic [LW-1:0] model(input logic [LW-1:0] v, input int n, input bit loop);
    logic [LW-1:0]    r;
    logic [WIDTH-1:0] x;
    int               nn;
    nn = (n > 32) ? 32 : n;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      x = v[k*WIDTH +: WIDTH];
      for (int i = 0; i < nn; i++) x = {x[WIDTH-2:0], loop ? x[WIDTH-1] : 1'b1};
      r[k*WIDTH +: WIDTH] = x;
    end
    return r;
  endfunction

  // Monitor: counts clk_sh pulses, measures high-phase width, checks each done.
  initial begin
    logic sh_prev;
    int   hrun;
    exp_t e;
    sh_prev = 1'b0;
    hrun = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sh_prev = 1'b0;
        hrun = 0;
      end else begin
        if (bus.clk_sh && !sh_prev) pulses_total++;
        if (bus.clk_sh) hrun++;
        else begin
          if (hrun > 0) last_hw = hrun;
          hrun = 0;
        end
        sh_prev = bus.clk_sh;
        if (bus.done) begin
          if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_done: got done=1 expected no pending request at cycle %0d", cyc);
          end else begin
            e = sb.pop_front();
            chk("din_out", bus.din_out, e.din);
            chk("latency", LW'(cyc - e.start_cyc), LW'(e.lat));
            chk("pulses", LW'(pulses_total - e.pbase), LW'(e.pulses));
            if (e.pulses > 0) chk("high_width", LW'(last_hw), LW'(e.hw));
          end
        end
      end
    end
  end

  task automatic launch(input int n, input int hp, input bit loop,
                        input logic [LW-1:0] din_v, input logic [LW-1:0] exp_v);
    exp_t e;
    int   ns;
    int   ha;
    ns = (n > 32) ? 32 : n;
    ha = (hp == 0) ? 1 : hp;
    @(negedge clk);
    loop_mode       = loop;
    bus.bit_cnt     = 6'(n);
    bus.half_period = 8'(hp);
    bus.dout_in     = din_v;
    bus.start       = 1'b1;
    e.din = exp_v;  e.lat = 2*ns*ha + 2;  e.pulses = ns;
    e.start_cyc = cyc;  e.pbase = pulses_total;  e.hw = ha;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  logic [LW-1:0] v_basic, v_part, v_alt, last_exp;
  int            cnt;
  logic          p;

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.bit_cnt = '0;
    bus.half_period = '0;
    bus.dout_in = '0;
    for (int k = 0; k < LANES; k++) begin
      v_basic[k*WIDTH +: WIDTH] = 32'hA5A50000 + 32'(k);
      v_part[k*WIDTH +: WIDTH]  = 32'h12345678 + 32'(k) * 32'h01010101;
      v_alt[k*WIDTH +: WIDTH]   = 32'hC0DE0000 ^ (32'(k) << 4);
    end

    // Reset state.
    #12;
    chk("rst_busy", LW'(bus.busy), '0);
    chk("rst_done", LW'(bus.done), '0);
    chk("rst_clk_sh", LW'(bus.clk_sh), '0);
    chk("rst_din_out", bus.din_out, '0);
    chk("rst_sh_dout", LW'(bus.sh_dout), '0);
    @(negedge clk);
    rst = 1'b0;

    // Basic: full 32-bit loopback returns the original data.
    launch(32, 1, 1'b1, v_basic, v_basic);
    drain(80);
    // Partial: 4 bits, half period 3, ones shifted in.
    launch(4, 3, 1'b0, v_part, model(v_part, 4, 1'b0));
    drain(40);
    chk("partial_lane0", LW'(bus.din_out[31:0]), LW'(32'h2345678F));
    // Zero bits: done two cycles after start, data unchanged.
    launch(0, 5, 1'b1, v_alt, v_alt);
    drain(10);
    // bit_cnt saturates to 32.
    launch(63, 1, 1'b0, v_part, {LW{1'b1}});
    drain(80);
    // half_period 0 behaves as 1.
    launch(4, 0, 1'b1, v_alt, model(v_alt, 4, 1'b1));
    drain(20);
    // Start while busy is ignored.
    launch(8, 2, 1'b1, v_basic, model(v_basic, 8, 1'b1));
    repeat (5) @(negedge clk);
    bus.bit_cnt = 6'd3;
    bus.dout_in = v_alt;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    drain(50);
    last_exp = model(v_basic, 8, 1'b1);

    // Abort during the 10th high phase.
    @(negedge clk);
    loop_mode = 1'b1;
    bus.bit_cnt = 6'd32;
    bus.half_period = 8'd1;
    bus.dout_in = v_alt;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0;
    p = 1'b0;
    for (int i = 0; i < 100 && !(cnt == 10 && bus.clk_sh); i++) begin
      @(posedge clk);
      #1;
      if (bus.clk_sh && !p) cnt++;
      p = bus.clk_sh;
    end
    chk("abort_reached_high10", LW'(cnt), LW'(10));
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    chk("abort_clk_sh", LW'(bus.clk_sh), '0);
    chk("abort_busy", LW'(bus.busy), '0);
    chk("abort_din_out", bus.din_out, last_exp);
    repeat (70) @(negedge clk);
    chk("abort_idle", LW'(bus.busy), '0);

    // Reset during LOW, then a normal run.
    @(negedge clk);
    bus.bit_cnt = 6'd8;
    bus.half_period = 8'd3;
    bus.dout_in = v_part;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", LW'(bus.busy), '0);
    chk("midrst_clk_sh", LW'(bus.clk_sh), '0);
    chk("midrst_din_out", bus.din_out, '0);
    chk("midrst_sh_dout", LW'(bus.sh_dout), '0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    launch(5, 2, 1'b0, v_part, model(v_part, 5, 1'b0));
    drain(40);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
